// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the front-end stages.
//   XLEN     : architectural register/PC width
//   NOP_INST : instruction decode substitutes when the queue presents no entry
//   if_entry_t : one fetched {pc, inst} pair as held in the instruction queue
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH-entry storage array for fetched {pc, inst} pairs.
// The write port is registered and the read port is combinational.
// The storage has no reset; its owner decides when an entry is valid.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : entry to store
//   raddr : read index
//   rdata : entry currently stored at raddr
module sync_fifo_mem
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output if_entry_t     rdata
);

  if_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO between fetch and decode.
// Fetched {pc, inst} pairs are captured and the oldest pair is presented to
// decode through a valid/ready handshake. Fetch is stalled while the queue is
// full. A flush from a taken branch empties the queue.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : branch redirect; drops everything, including this cycle's input
//   in_valid/in_pc/in_inst : word offered by fetch
//   in_ready       : queue can take a word (not full)
//   fetch_stall    : inverse of in_ready, drives the fetch stall input
//   out_valid/out_pc/out_inst : head entry; pc/inst read as 0 while empty
//   out_misaligned : head entry has a PC that is not word aligned
//   out_ready      : decode consumes the head this cycle
//   count          : occupancy, 0..DEPTH
module inst_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            in_ready,
  output logic            fetch_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_misaligned,
  input  logic            out_ready,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  if_entry_t     wr_entry;
  if_entry_t     head;

  // Handshake status depends only on the registered count, so neither
  // out_ready nor flush reaches in_ready combinationally.
  assign in_ready    = (count != FULL_CNT);
  assign fetch_stall = ~in_ready;
  assign out_valid   = (count != '0);

  // A full queue refuses a push even when a pop happens in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_inst;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is never cleared, so stale entries are masked while empty.
  assign out_pc         = out_valid ? head.pc   : '0;
  assign out_inst       = out_valid ? head.inst : '0;
  assign out_misaligned = out_valid & (out_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            in_ready;
  logic            fetch_stall;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_misaligned;
  logic            out_ready;
  logic [AW:0]     count;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb [$];

  inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .fetch_stall    (fetch_stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misaligned (out_misaligned),
    .out_ready      (out_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic step();
    logic [63:0] head;
    logic [63:0] obs;
    logic [63:0] exp;
    logic        do_push;
    logic        do_pop;
    int          n;
    n    = sb.size();
    head = (n != 0) ? sb[0] : 64'd0;
    obs  = {out_pc, out_inst};
    chk("count",     64'(count),        64'(n));
    chk("in_ready",  64'(in_ready),     64'(n != DEPTH));
    chk("stall",     64'(fetch_stall),  64'(n == DEPTH));
    chk("out_valid", 64'(out_valid),    64'(n != 0));
    chk("head",      obs,               head);
    chk("misalign",  64'(out_misaligned), 64'((n != 0) && (head[33:32] != 2'b00)));
    do_push = rst_n && !flush && in_valid && (n < DEPTH);
    do_pop  = rst_n && !flush && out_ready && (n > 0);
    @(posedge clk);
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        exp = sb.pop_front();
        chk("pop_data", obs, exp);
      end
      if (do_push) sb.push_back({in_pc, in_inst});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_count",  64'(count),     64'd0);
    chk("rst_ready",  64'(in_ready),  64'd1);
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_pc",     64'(out_pc),    64'd0);
    rst_n = 1'b1;
    step();

    // single push then pop
    drive(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    step();
    chk("single_vld",  64'(out_valid), 64'd1);
    chk("single_inst", 64'(out_inst),  64'h0050_0093);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("single_pop", 64'(count), 64'd0);

    // fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    chk("full_count", 64'(count),       64'd4);
    chk("full_stall", 64'(fetch_stall), 64'd1);
    drive(1'b1, 32'h10, 32'h2000, 1'b1, 1'b0);
    step();
    chk("full_refuse", 64'(count), 64'd3);
    chk("after_head",  64'(out_pc), 64'h4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end
    chk("drained", 64'(count), 64'd0);

    // wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 32'h3000 + 32'(i), 1'b1, 1'b0);
      step();
      chk("stream_cnt", 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h100, 32'h5000, 1'b1, 1'b1);
    step();
    chk("flush_cnt", 64'(count),     64'd0);
    chk("flush_vld", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h200, 32'h6000, 1'b0, 1'b0);
    step();
    chk("redirect_head", 64'(out_pc), 64'h200);

    // mid-operation reset, then a misaligned entry
    drive(1'b1, 32'h204, 32'h6001, 1'b0, 1'b0);
    step();
    chk("pre_rst_cnt", 64'(count), 64'd2);
    rst_n = 1'b0;
    drive(1'b1, 32'h208, 32'h6002, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;
    chk("mid_rst_cnt", 64'(count), 64'd0);
    drive(1'b1, 32'h6, 32'h7000, 1'b0, 1'b0);
    step();
    chk("misaligned", 64'(out_misaligned), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
